// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, flag bit positions and the
// writeback FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_PASSTHROUGH = 4'h0;
    localparam logic [3:0] ALU_ADD         = 4'h1;
    localparam logic [3:0] ALU_SUBTRACT    = 4'h2;
    localparam logic [3:0] ALU_MULTIPLY    = 4'h3;
    localparam logic [3:0] ALU_AND         = 4'h4;
    localparam logic [3:0] ALU_OR          = 4'h5;
    localparam logic [3:0] ALU_XOR         = 4'h6;
    localparam logic [3:0] ALU_COMPLEMENT  = 4'h7;

    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wb_state_t;

    function automatic logic is_multiply(input logic [3:0] op);
        return op == ALU_MULTIPLY;
    endfunction

endpackage

// File: rtl/alu_writeback.sv
// ALU writeback stage: captures one ALU result per handshake, writes it to the
// register file (two byte writes for multiply) and commits the flag register.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [2*DATA_W-1:0]   result,
    input  logic [2:0]            flags,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    input  logic                  flag_we,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [2:0]            flag_reg,
    output logic                  stall
);

    wb_state_t state, state_next;

    logic [3:0]            op_p1;
    logic [2*DATA_W-1:0]   result_p1;
    logic [2:0]            flags_p1;
    logic [REG_ADDR_W-1:0] dest_p1;
    logic                  flag_we_p1;

    logic accept;
    logic held_mul;
    logic final_write;

    // High byte goes to the next register; the address width makes 7 wrap to 0.
    function automatic logic [REG_ADDR_W-1:0] hi_addr(input logic [REG_ADDR_W-1:0] a);
        return a + REG_ADDR_W'(1);
    endfunction

    assign held_mul    = is_multiply(op_p1);
    assign accept      = in_valid && in_ready;
    assign final_write = (state == WR_LO && !held_mul) || (state == WR_HI);

    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            WR_LO:   in_ready = !held_mul;
            WR_HI:   in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign stall = !in_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? WR_LO : IDLE;
            WR_LO: begin
                if (held_mul)    state_next = WR_HI;
                else if (accept) state_next = WR_LO;
                else             state_next = IDLE;
            end
            WR_HI:   state_next = accept ? WR_LO : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Stage p0 -> p1: capture the accepted result into the holding registers.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_p1      <= operation;
            result_p1  <= result;
            flags_p1   <= flags;
            dest_p1    <= dest_reg;
            flag_we_p1 <= flag_we;
        end
    end

    // Stage p1 -> architectural state: flags commit after the last byte write.
    always_ff @(posedge clock) begin
        if (reset)                          flag_reg <= 3'b000;
        else if (final_write && flag_we_p1) flag_reg <= flags_p1;
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (state)
            WR_LO: begin
                rf_we    = 1'b1;
                rf_waddr = dest_p1;
                rf_wdata = result_p1[DATA_W-1:0];
            end
            WR_HI: begin
                rf_we    = 1'b1;
                rf_waddr = hi_addr(dest_p1);
                rf_wdata = result_p1[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

endmodule
